mem_ls_responder: RTL
=====================

# mem_ls_responder

Memory-side responder for the multicycle CPU's load/store path. It accepts one sub-word load or store request at a time from the CPU control unit, runs the access against the word-wide data memory, and returns the loaded value extended to 32 bits. Stores use read-modify-write when the size is byte or half, and a direct write when the size is word. It sits between the control unit/MDR datapath and the synchronous data memory, and owns byte-lane selection, alignment checking and extension.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles from the `mem_rd` cycle until `mem_rdata` is valid; legal range 1..7.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid&req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  01 byte, 10 half, 11 word, 00 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid: misaligned or illegal size.
- resp_rdata  out  32  extended load data; held until the next response.
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- mem_wdata  out  32  merged write word.
- mem_rdata  in  32  memory read data.

## Operation
- Lane mapping is little-endian. Byte offset k=addr[1:0] occupies bits [8k+7:8k]. Half offset addr[1]=h occupies bits [16h+15:16h].
- Error cases: size 00; half with addr[0]=1; word with addr[1:0]≠0. On error the block goes straight to RESP with resp_err=1 and makes no memory access. resp_rdata is left unchanged.
- States: IDLE, READ, WAIT, WRITE, RESP.
- IDLE: on accept, latch all request fields, then:
  - error → RESP
  - word store → WRITE
  - otherwise → READ
- READ: mem_rd=1 for exactly one cycle → WAIT.
- WAIT: counts MEM_LATENCY cycles. At the final WAIT edge, mem_rdata is captured into the data register.
  - load → RESP
  - store → WRITE
- WRITE: mem_wr=1 for one cycle. mem_wdata is either the captured word with the selected lane replaced by req_wdata[7:0]/[15:0], or req_wdata for a word store. → RESP.
- RESP: resp_valid=1 for one cycle. For loads, resp_rdata = the extracted lane, sign- or zero-extended. For stores, resp_rdata is unchanged. → IDLE.
- The response cannot be back-pressured; the control unit samples it in that cycle.
- mem_addr, mem_rd, mem_wr and mem_wdata are driven from registered state and are glitch-free.

## Timing
Latencies are measured from the accept edge E0 to the cycle in which resp_valid is high (MEM_LATENCY=1):
- load: READ, WAIT, RESP → resp_valid in cycle 3.
- byte/half store: READ, WAIT, WRITE, RESP → 4.
- word store: WRITE, RESP → 2.
- error: RESP → 1.
- General formula: load 2+MEM_LATENCY; sub-word store 3+MEM_LATENCY.

Reset values, all outputs: req_ready=1 (state IDLE); resp_valid, resp_err, mem_rd and mem_wr = 0; resp_rdata, mem_wdata and mem_addr = 0.

Reset asserted mid-operation: strobes drop asynchronously and any in-flight write is abandoned (no partial write). No response is issued. The block resumes in IDLE on the first edge after release.

Back-to-back requests: req_ready rises the cycle after RESP. The minimum request spacing is the latency plus 1 cycle.

## Structure
- Package `ls_pkg`:
  - size encodings: SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum
  - MEM_LATENCY range limits
- Sub-module `ls_lane_unit`: purely combinational. Lane merge for stores (word, offset, size, wdata → merged word) and lane extract plus extension for loads. It is instantiated once; the FSM, latency counter and registers stay in the top.

## Test plan
- Load byte, signed, addr 0x103, mem word 0x80AA5511 → resp_rdata 0xFFFFFF80, err=0, resp_valid in cycle 3; unsigned → 0x00000080.
- Store half 0xBEEF at addr 0x202, mem word 0x11223344 → one mem_rd at 0x200, then mem_wr with 0xBEEF3344; resp_valid in cycle 4.
- Store word 0xDEADBEEF at 0x300 → no mem_rd, mem_wr with 0xDEADBEEF, resp_valid in cycle 2.
- Half load at 0x001 and word store at 0x002 → resp_err=1 in cycle 1, mem_rd and mem_wr never asserted, resp_rdata unchanged.
- MEM_LATENCY=3, byte store 0x5A at 0x001 over 0xFFFFFFFF → mem_wdata 0xFFFF5AFF, resp_valid in cycle 6.
- Reset pulsed during WRITE → mem_wr drops immediately, no resp_valid; a next load completes normally.

Source files
------------

// File: rtl/ls_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ls_pkg                                                 |
// | Brief   : Shared types and constants for the load/store responder|
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
package ls_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } ls_size_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } ls_state_e;

  localparam int c_mem_latency_min = 1;
  localparam int c_mem_latency_max = 7;
  localparam int c_lat_cnt_w       = 3;

  // Illegal size, or an offset that does not fall on the natural boundary.
  function automatic logic ls_access_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = off[0];
      SZ_WORD: err = (off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ls_lane_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ls_lane_unit                                           |
// | Brief   : Little-endian lane merge (stores) and extract (loads)  |
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
module ls_lane_unit
  import ls_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  ls_size_e    i_size,
  input  logic [31:0] i_wdata,
  input  logic        i_sign_ext,
  output logic [31:0] o_merged,
  output logic [31:0] o_extracted
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

  always_comb begin
    o_merged    = i_word;
    o_extracted = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_merged[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
        o_extracted = {{24{i_sign_ext & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_merged[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
        o_extracted = {{16{i_sign_ext & w_half[15]}}, w_half};
      end
      SZ_WORD: o_merged = i_wdata;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_ls_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : mem_ls_responder                                       |
// | Brief   : Sub-word load/store responder with RMW over word memory|
// | Rev     : 1.0                                                    |
// +------------------------------------------------------------------+
module mem_ls_responder
  import ls_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int c_lat = (MEM_LATENCY < c_mem_latency_min) ? c_mem_latency_min :
                         (MEM_LATENCY > c_mem_latency_max) ? c_mem_latency_max : MEM_LATENCY;
  localparam logic [c_lat_cnt_w-1:0] c_wait_last = c_lat_cnt_w'(c_lat - 1);

  ls_state_e               r_state, w_next;
  logic                    r_write, r_signed;
  ls_size_e                r_size;
  logic [1:0]              r_off;
  logic [15:0]             r_wdata;
  logic [c_lat_cnt_w-1:0]  r_cnt;
  logic                    r_mem_rd, r_mem_wr, r_resp_valid, r_resp_err;
  logic [31:0]             r_mem_addr, r_mem_wdata, r_resp_rdata;

  logic        w_accept, w_req_err, w_wait_done;
  logic [31:0] w_merged, w_extracted;

  assign req_ready   = (r_state == S_IDLE);
  assign w_accept    = req_valid & req_ready;
  assign w_req_err   = ls_access_err(req_size, req_addr[1:0]);
  assign w_wait_done = (r_state == S_WAIT) && (r_cnt == c_wait_last);

  ls_lane_unit u_lane (
    .i_word      (mem_rdata),
    .i_offset    (r_off),
    .i_size      (r_size),
    .i_wdata     ({16'h0000, r_wdata}),
    .i_sign_ext  (r_signed),
    .o_merged    (w_merged),
    .o_extracted (w_extracted)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                              w_next = S_RESP;
          else if (req_write && (req_size == SZ_WORD)) w_next = S_WRITE;
          else                                        w_next = S_READ;
        end
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT:  if (w_wait_done) w_next = r_write ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are registered off the next state so the memory sees clean, glitch-free pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_write      <= 1'b0;
      r_signed     <= 1'b0;
      r_size       <= SZ_NONE;
      r_off        <= 2'b00;
      r_wdata      <= 16'h0000;
      r_cnt        <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_resp_rdata <= 32'h0;
    end else begin
      r_mem_rd     <= (w_next == S_READ);
      r_mem_wr     <= (w_next == S_WRITE);
      r_resp_valid <= (w_next == S_RESP);
      // Only the error path jumps from IDLE straight to RESP.
      r_resp_err   <= (w_next == S_RESP) && (r_state == S_IDLE);
      r_cnt        <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;

      if (w_accept) begin
        r_write    <= req_write;
        r_signed   <= req_signed;
        r_size     <= ls_size_e'(req_size);
        r_off      <= req_addr[1:0];
        r_wdata    <= req_wdata[15:0];
        r_mem_addr <= {req_addr[31:2], 2'b00};
        if (w_next == S_WRITE) r_mem_wdata <= req_wdata;
      end

      if (w_wait_done) begin
        if (r_write) r_mem_wdata  <= w_merged;
        else         r_resp_rdata <= w_extracted;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_rd     = r_mem_rd;
  assign mem_wr     = r_mem_wr;
  assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire
